// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response codes and bridge FSM state encoding
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        WR_RESP = 3'd2,
        RD_ACC  = 3'd3,
        RD_RESP = 3'd4
    } bridge_state_e;

    // Arbiter priority encoding: which side wins when both are eligible
    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

endpackage

// File: rtl/axil_req_holder.sv
// rtl/axil_req_holder.sv - one-entry valid/ready holding register with registered ready
module axil_req_holder #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         allow_d,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_q, full_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data_q, data_d;

    // Capture on handshake, free on clear; ready is precomputed for next cycle
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end
        if (in_valid && ready_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end
        ready_d = !full_d && allow_d;
    end

    // Holder state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign in_ready = ready_q;
    assign full     = full_q;
    assign data     = data_q;

endmodule

// File: rtl/axil_reg_bridge.sv
// rtl/axil_reg_bridge.sv - AXI4-Lite to req/ack register bus bridge; AXIL_REG_BRIDGE_TIMEOUT_EN adds an ack timeout
module axil_reg_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                reg_req,
    output logic                reg_we,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W/8-1:0] reg_wstrb,
    input  logic                reg_ack,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic                reg_err
);

    localparam int SW = DATA_W / 8;

    bridge_state_e       state_q, state_d;
    logic                prio_q, prio_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    resp_e               bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    resp_e               rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                aw_full, w_full, ar_full;
    logic [ADDR_W-1:0]   aw_data, ar_data;
    logic [DATA_W+SW-1:0] w_data;
    logic                wr_clear, rd_clear;
    logic                allow_d;
    logic                ack;
    logic                timeout;

    assign allow_d = (state_d == IDLE);
    // An ack outside an active request is meaningless and ignored
    assign ack     = reg_ack && req_q;

    axil_req_holder #(.W(ADDR_W)) u_aw_hold (
        .clk(aclk), .resetn(aresetn),
        .in_data(s_awaddr), .in_valid(s_awvalid), .in_ready(s_awready),
        .allow_d(allow_d), .clear(wr_clear), .full(aw_full), .data(aw_data)
    );

    axil_req_holder #(.W(DATA_W + SW)) u_w_hold (
        .clk(aclk), .resetn(aresetn),
        .in_data({s_wstrb, s_wdata}), .in_valid(s_wvalid), .in_ready(s_wready),
        .allow_d(allow_d), .clear(wr_clear), .full(w_full), .data(w_data)
    );

    axil_req_holder #(.W(ADDR_W)) u_ar_hold (
        .clk(aclk), .resetn(aresetn),
        .in_data(s_araddr), .in_valid(s_arvalid), .in_ready(s_arready),
        .allow_d(allow_d), .clear(rd_clear), .full(ar_full), .data(ar_data)
    );

`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cycles spent waiting for ack; restarts each time a request is issued
    always_comb begin
        cnt_d = '0;
        if (state_q == WR_ACC || state_q == RD_ACC) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Bridge FSM next state: arbitration, register access, response hold
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        wr_clear = 1'b0;
        rd_clear = 1'b0;
        case (state_q)
            IDLE: begin
                // Whichever side is granted hands priority to the other one
                if (ar_full && (!(aw_full && w_full) || prio_q == PRIO_RD)) begin
                    state_d = RD_ACC;
                    prio_d  = PRIO_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ar_data;
                    wstrb_d = '0;
                end else if (aw_full && w_full) begin
                    state_d = WR_ACC;
                    prio_d  = PRIO_RD;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = aw_data;
                    wdata_d = w_data[DATA_W-1:0];
                    wstrb_d = w_data[DATA_W+SW-1:DATA_W];
                end
            end
            WR_ACC: begin
                if (ack || timeout) begin
                    state_d  = WR_RESP;
                    req_d    = 1'b0;
                    wr_clear = 1'b1;
                    bvalid_d = 1'b1;
                    bresp_d  = (ack && !reg_err) ? OKAY : SLVERR;
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            RD_ACC: begin
                if (ack || timeout) begin
                    state_d  = RD_RESP;
                    req_d    = 1'b0;
                    rd_clear = 1'b1;
                    rvalid_d = 1'b1;
                    rresp_d  = (ack && !reg_err) ? OKAY : SLVERR;
                    rdata_d  = ack ? reg_rdata : '0;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Bridge FSM and all registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            prio_q   <= PRIO_RD;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign reg_req   = req_q;
    assign reg_we    = we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb/tb_axil_reg_bridge.sv - directed self-checking bench for axil_reg_bridge
module tb_axil_reg_bridge;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic        reg_req, reg_we;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;

    axil_reg_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Register-side responder configuration and access log
    int          ack_delay = 0;
    bit          ack_en    = 1'b1;
    logic [31:0] ack_rdata = 32'h0;
    logic        ack_err   = 1'b0;
    int          rcnt      = 0;
    logic        log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_wstrb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // sel: 0 = reg_req, 1 = s_bvalid, 2 = s_rvalid
    task automatic wait_sig(input int sel, input int max, input string tag, output int cycles);
        logic s;
        cycles = 0;
        s = (sel == 0) ? reg_req : (sel == 1) ? s_bvalid : s_rvalid;
        while (!s && cycles < max) begin
            tick();
            cycles++;
            s = (sel == 0) ? reg_req : (sel == 1) ? s_bvalid : s_rvalid;
        end
        if (!s) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    // Responder: acks after ack_delay extra cycles of reg_req, logs each access
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        reg_err   = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (reg_ack) begin
                reg_ack = 1'b0;
                rcnt    = 0;
            end else if (!reg_req) begin
                rcnt = 0;
            end else if (ack_en) begin
                if (rcnt == ack_delay) begin
                    reg_ack   = 1'b1;
                    reg_rdata = ack_rdata;
                    reg_err   = ack_err;
                    log_we.push_back(reg_we);
                    log_addr.push_back(reg_addr);
                    log_wdata.push_back(reg_wdata);
                    log_wstrb.push_back(reg_wstrb);
                end else begin
                    rcnt++;
                end
            end
        end
    end

    initial begin
        int cyc;
        int base;
        logic bad;
        logic [31:0] held;

        aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        tick();
        tick();
        check("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
        check("rst_valids", {s_bvalid, s_rvalid, reg_req}, 3'b000);
        check("rst_data", {s_rdata, s_bresp, s_rresp}, 36'h0);
        check("rst_reg", {reg_we, reg_addr, reg_wdata, reg_wstrb}, 69'h0);
        aresetn = 1'b1;
        tick();
        check("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);

        // 1: AW and W in the same cycle, ack on the second request cycle
        ack_delay = 1;
        s_awaddr = 32'h10; s_awvalid = 1;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check("t1_awready_busy", s_awready, 1'b0);
        wait_sig(0, 10, "t1_req", cyc);
        check("t1_req_latency", cyc, 1);
        check("t1_req_fields", {reg_we, reg_addr, reg_wdata, reg_wstrb}, {1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
        wait_sig(1, 10, "t1_bvalid", cyc);
        check("t1_b_latency", cyc, 2);
        check("t1_b", {reg_req, s_bresp}, {1'b0, 2'b00});
        s_bready = 1;
        tick();
        s_bready = 0;
        check("t1_b_done", s_bvalid, 1'b0);
        check("t1_log_count", log_we.size(), 1);

        // 2: W three cycles ahead of AW
        base = log_we.size();
        ack_delay = 0;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'h3; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        tick();
        tick();
        check("t2_no_req", {reg_req, s_wready}, 2'b00);
        s_awaddr = 32'h24; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        wait_sig(0, 10, "t2_req", cyc);
        check("t2_req_latency", cyc, 1);
        wait_sig(1, 10, "t2_bvalid", cyc);
        check("t2_bresp", s_bresp, 2'b00);
        s_bready = 1;
        tick();
        s_bready = 0;
        check("t2_log_count", log_we.size() - base, 1);
        if (log_we.size() > base)
            check("t2_access", {log_we[base], log_addr[base], log_wdata[base], log_wstrb[base]},
                  {1'b1, 32'h24, 32'hCAFEF00D, 4'h3});

        // 3: read with a slow ack and a stalled R channel
        ack_delay = 5; ack_rdata = 32'h12345678;
        s_araddr = 32'h20; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        wait_sig(0, 10, "t3_req", cyc);
        check("t3_req_fields", {reg_we, reg_addr}, {1'b0, 32'h20});
        wait_sig(2, 20, "t3_rvalid", cyc);
        check("t3_r_latency", cyc, 6);
        held = s_rdata;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!s_rvalid || s_rdata !== held || s_arready) bad = 1'b1;
        end
        check("t3_r_stable", bad, 1'b0);
        check("t3_r", {s_rdata, s_rresp}, {32'h12345678, 2'b00});
        s_rready = 1;
        tick();
        s_rready = 0;
        check("t3_after_r", {s_rvalid, s_arready}, 2'b01);

        // 4: AR, AW, W together four times after reset -> R,W,R,W...
        do_reset();
        ack_delay = 0;
        s_bready = 1; s_rready = 1;
        base = log_we.size();
        for (int r = 0; r < 4; r++) begin
            s_araddr = 32'h100 + r; s_arvalid = 1;
            s_awaddr = 32'h200 + r; s_awvalid = 1;
            s_wdata = 32'h5000 + r; s_wstrb = 4'hF; s_wvalid = 1;
            tick();
            s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
            cyc = 0;
            while (log_we.size() < base + 2 * (r + 1) && cyc < 40) begin
                tick();
                cyc++;
            end
            for (int k = 0; k < 4; k++) tick();
        end
        check("t4_log_count", log_we.size() - base, 8);
        for (int k = 0; k < 8 && base + k < log_we.size(); k++) begin
            check($sformatf("t4_order_%0d", k), {log_we[base + k], log_addr[base + k]},
                  {(k % 2 == 1), ((k % 2 == 1) ? 32'h200 : 32'h100) + 32'(k / 2)});
        end
        s_bready = 0; s_rready = 0;

        // 5: read error at minimum latency, then reset during RD_ACC
        ack_err = 1; ack_rdata = 32'hA5A50001;
        s_araddr = 32'h30; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        wait_sig(2, 10, "t5_rvalid", cyc);
        check("t5_min_latency", cyc, 2);
        check("t5_r_err", {s_rdata, s_rresp}, {32'hA5A50001, 2'b10});
        s_rready = 1;
        tick();
        s_rready = 0;
        ack_err = 0;
        ack_en = 0;
        base = log_we.size();
        s_araddr = 32'h34; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        wait_sig(0, 10, "t5_req", cyc);
        aresetn = 0;
        tick();
        check("t5_rst_outputs", {s_rvalid, reg_req}, 2'b00);
        aresetn = 1;
        ack_en = 1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_rvalid || reg_req) bad = 1'b1;
        end
        check("t5_no_resp", bad, 1'b0);
        check("t5_no_access", log_we.size() - base, 0);

`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
        // 6: write never acked times out after TIMEOUT_CYCLES
        ack_en = 0;
        s_awaddr = 32'h40; s_awvalid = 1;
        s_wdata = 32'h1; s_wstrb = 4'h1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        wait_sig(0, 10, "t6_req", cyc);
        wait_sig(1, 40, "t6_bvalid", cyc);
        check("t6_timeout_latency", cyc, 16);
        check("t6_b", {reg_req, s_bresp}, {1'b0, 2'b10});
        s_bready = 1;
        tick();
        s_bready = 0;
        ack_en = 1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
